// File: rtl/tt_sweep_checker.sv
// Truth-table sweeper/checker: walks vec through every input combination,
// samples s_in once per vector and compares the captured map against exp_map.
module tt_sweep_checker #(
    parameter int unsigned N_IN   = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(2**N_IN)-1:0]   exp_map,
    output logic [N_IN-1:0]        vec,
    input  logic                   s_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(2**N_IN)-1:0]   map,
    output logic [N_IN:0]          err_cnt,
    output logic [N_IN-1:0]        err_idx
);

    localparam int unsigned      MAP_W       = 2**N_IN;
    localparam int unsigned      CNT_W       = N_IN + 1;
    localparam logic [N_IN-1:0]  VEC_LAST    = '1;
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [N_IN-1:0]    vec_q;
    logic [MAP_W-1:0]   map_q;
    logic [MAP_W-1:0]   map_d;
    logic [MAP_W-1:0]   exp_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [CNT_W-1:0]   err_cnt_d;
    logic [N_IN-1:0]    err_idx_q;
    logic [N_IN-1:0]    err_idx_d;
    logic [3:0]         settle_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               mismatch;

    // Result of sampling the current vector; only committed in SAMPLE.
    always_comb begin
        mismatch       = s_in ^ exp_q[vec_q];
        map_d          = map_q;
        map_d[vec_q]   = s_in;
        err_cnt_d      = err_cnt_q + CNT_W'(mismatch);
        err_idx_d      = err_idx_q;
        if (mismatch && (err_cnt_q == '0)) begin
            err_idx_d = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            map_q     <= '0;
            exp_q     <= '0;
            err_cnt_q <= '0;
            err_idx_q <= '0;
            settle_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_DRIVE;
                        vec_q     <= '0;
                        map_q     <= '0;
                        exp_q     <= exp_map;
                        err_cnt_q <= '0;
                        err_idx_q <= '0;
                        settle_q  <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        state_q  <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    map_q     <= map_d;
                    err_cnt_q <= err_cnt_d;
                    err_idx_q <= err_idx_d;
                    if (vec_q == VEC_LAST) begin
                        // pass uses the count including this last vector
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_d == '0);
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        state_q <= S_DRIVE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vec     = vec_q;
    assign map     = map_q;
    assign err_cnt = err_cnt_q;
    assign err_idx = err_idx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two configurations checked every cycle against a
// time-based model (edges elapsed since start decide vec, map and verdict).
module tb_tt_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // Instance A: N_IN=3, SETTLE=1
    logic       start_a;
    logic [7:0] exp_a;
    logic [7:0] fmap_a;
    logic [2:0] vec_a;
    logic       s_in_a;
    logic       glit_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] map_a;
    logic [3:0] ecnt_a;
    logic [2:0] eidx_a;

    // Instance B: N_IN=2, SETTLE=3
    logic       start_b;
    logic [3:0] exp_b;
    logic [3:0] fmap_b;
    logic [1:0] vec_b;
    logic       s_in_b;
    logic       glit_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] map_b;
    logic [2:0] ecnt_b;
    logic [1:0] eidx_b;

    // The "function blocks": combinational from vec, with glitches in DRIVE cycles.
    assign s_in_a = fmap_a[vec_a] ^ glit_a;
    assign s_in_b = fmap_b[vec_b] ^ glit_b;

    tt_sweep_checker #(.N_IN(3), .SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .exp_map(exp_a), .vec(vec_a),
        .s_in(s_in_a), .busy(busy_a), .done(done_a), .pass(pass_a), .map(map_a),
        .err_cnt(ecnt_a), .err_idx(eidx_a));

    tt_sweep_checker #(.N_IN(2), .SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .exp_map(exp_b), .vec(vec_b),
        .s_in(s_in_b), .busy(busy_b), .done(done_b), .pass(pass_b), .map(map_b),
        .err_cnt(ecnt_b), .err_idx(eidx_b));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit          act;
        logic [31:0] m;     // edges elapsed since the start-sampling edge
        logic [7:0]  f;
        logic [7:0]  e;
    } mdl_t;

    typedef struct packed {
        logic [2:0] vec;
        logic [7:0] map;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] ecnt;
        logic [2:0] eidx;
    } exp_t;

    localparam int unsigned TOT_A = 8 * 2;
    localparam int unsigned TOT_B = 4 * 4;

    mdl_t ma, mb;
    bit   mvalid = 1'b0;

    function automatic mdl_t step(input mdl_t s, input logic rst, input logic st,
                                  input logic [7:0] f, input logic [7:0] e, input int unsigned tot);
        mdl_t r;
        r = s;
        if (!rst) begin
            r.act = 1'b0;
            r.m   = 0;
        end else if ((!s.act || s.m >= tot) && st) begin
            r.act = 1'b1;
            r.m   = 0;
            r.f   = f;
            r.e   = e;
        end else if (s.act && s.m < tot) begin
            r.m = s.m + 1;
        end
        return r;
    endfunction

    function automatic exp_t model_out(input int unsigned n, input int unsigned s, input mdl_t md);
        exp_t        x;
        int unsigned per, tot, cnt, nv;
        logic [7:0]  mask, diff;
        bit          found;
        x = '0;
        if (!md.act) return x;
        nv   = 1 << n;
        per  = s + 1;
        tot  = nv * per;
        cnt  = md.m / per;
        if (cnt > nv) cnt = nv;
        mask = '0;
        for (int unsigned i = 0; i < cnt; i++) mask[i] = 1'b1;
        x.busy = (md.m < tot);
        x.done = !x.busy;
        x.vec  = x.done ? 3'(nv - 1) : 3'(md.m / per);
        x.map  = md.f & mask;
        diff   = (md.f ^ md.e) & mask;
        found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (diff[i]) begin
                x.ecnt = x.ecnt + 4'd1;
                if (!found) begin
                    x.eidx = 3'(i);
                    found  = 1'b1;
                end
            end
        end
        x.pass = x.done && (diff == 8'h00);
        return x;
    endfunction

    // Single compare process: advance the model at each edge, check 1 time unit later.
    always begin
        exp_t xa, xb;
        @(posedge clk);
        if (!rst_n) mvalid = 1'b1;
        ma = step(ma, rst_n, start_a, fmap_a, exp_a, TOT_A);
        mb = step(mb, rst_n, start_b, {4'h0, fmap_b}, {4'h0, exp_b}, TOT_B);
        #1;
        if (mvalid) begin
            xa = model_out(3, 1, ma);
            xb = model_out(2, 3, mb);
            chk("A.vec", vec_a, xa.vec);       chk("A.map", map_a, xa.map);
            chk("A.busy", busy_a, xa.busy);    chk("A.done", done_a, xa.done);
            chk("A.pass", pass_a, xa.pass);    chk("A.err_cnt", ecnt_a, xa.ecnt);
            chk("A.err_idx", eidx_a, xa.eidx);
            chk("B.vec", vec_b, xb.vec);       chk("B.map", map_b, xb.map);
            chk("B.busy", busy_b, xb.busy);    chk("B.done", done_b, xb.done);
            chk("B.pass", pass_b, xb.pass);    chk("B.err_cnt", ecnt_b, xb.ecnt);
            chk("B.err_idx", eidx_b, xb.eidx);
        end
        glit_a = ma.act && (ma.m < TOT_A) && (((ma.m + 1) % 2) != 0) && ($urandom_range(0, 1) == 1);
        glit_b = mb.act && (mb.m < TOT_B) && (((mb.m + 1) % 4) != 0) && ($urandom_range(0, 1) == 1);
    end

    function automatic bit idle_both();
        return (!ma.act || ma.m >= TOT_A) && (!mb.act || mb.m >= TOT_B);
    endfunction

    task automatic wait_idle();
        int unsigned k;
        k = 0;
        while (!idle_both() && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            failures++;
            $display("FAIL wait_idle actual=busy expected=idle t=%0t", $time);
        end
    endtask

    // Start on the next edge; returns at the negedge after that edge + 16.
    task automatic sweep_a(input logic [7:0] f, input logic [7:0] e);
        fmap_a  = f;
        exp_a   = e;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        exp_a   = ~e;
        repeat (15) @(negedge clk);
        chk("A.done_before_16", done_a, 1'b0);
        @(negedge clk);
        chk("A.done_at_16", done_a, 1'b1);
    endtask

    initial begin
        ma = '0; mb = '0;
        glit_a = 1'b0; glit_b = 1'b0;
        rst_n = 1'b0;
        start_a = 1'b0; exp_a = '0; fmap_a = '0;
        start_b = 1'b0; exp_b = '0; fmap_b = '0;
        repeat (3) @(negedge clk);
        chk("rst.vec", vec_a, 0);   chk("rst.busy", busy_a, 0);
        chk("rst.done", done_a, 0); chk("rst.map", map_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // f = a~c | a~b c  -> minterms 4,5,6
        sweep_a(8'h70, 8'h70);
        chk("t1.map", map_a, 8'h70); chk("t1.pass", pass_a, 1); chk("t1.err_cnt", ecnt_a, 0);
        sweep_a(8'h70, 8'hF0);
        chk("t2.map", map_a, 8'h70); chk("t2.pass", pass_a, 0);
        chk("t2.err_cnt", ecnt_a, 1); chk("t2.err_idx", eidx_a, 7);
        sweep_a(8'h00, 8'hFF);
        chk("t3.err_cnt", ecnt_a, 8); chk("t3.err_idx", eidx_a, 0); chk("t3.pass", pass_a, 0);

        // Reset during DRIVE of vec=3
        fmap_a = 8'h70; exp_a = 8'h70; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4.vec_before_rst", vec_a, 3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t4.busy", busy_a, 0); chk("t4.vec", vec_a, 0); chk("t4.done", done_a, 0);
        sweep_a(8'h70, 8'h70);
        chk("t4.map", map_a, 8'h70); chk("t4.pass", pass_a, 1);

        // start held high: one sweep, then restart right after DONE
        fmap_a = 8'h70; exp_a = 8'h70; start_a = 1'b1;
        repeat (16) @(negedge clk);
        chk("t5.done_before_16", done_a, 0);
        @(negedge clk);
        chk("t5.done_at_16", done_a, 1);
        @(negedge clk);
        start_a = 1'b0;
        chk("t5.resweep_busy", busy_a, 1); chk("t5.resweep_vec", vec_a, 0);
        chk("t5.resweep_done", done_a, 0);
        wait_idle();

        // start and reset on the same edge
        start_a = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        start_a = 1'b0; rst_n = 1'b1;
        chk("rst_vs_start.busy", busy_a, 0);

        // s = vec[0]^vec[1] on the 2-input, SETTLE=3 instance
        fmap_b = 4'h6; exp_b = 4'h6; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; exp_b = 4'h0;
        repeat (15) @(negedge clk);
        chk("t6.done_before_16", done_b, 0);
        @(negedge clk);
        chk("t6.done_at_16", done_b, 1); chk("t6.pass", pass_b, 1); chk("t6.map", map_b, 4'h6);

        // Randomized sweeps with stray starts, exp_map churn and occasional reset
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            fmap_a = 8'($urandom);
            case ($urandom_range(0, 2))
                0: exp_a = fmap_a;
                1: exp_a = fmap_a ^ (8'h01 << $urandom_range(0, 7));
                default: exp_a = 8'($urandom);
            endcase
            fmap_b = 4'($urandom);
            exp_b  = ($urandom_range(0, 1) == 1) ? fmap_b : 4'($urandom);
            start_a = 1'b1;
            start_b = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int k = 0; k < int'($urandom_range(10, 24)); k++) begin
                start_a = ($urandom_range(0, 4) == 0);
                start_b = ($urandom_range(0, 4) == 0);
                exp_a   = 8'($urandom);
                exp_b   = 4'($urandom);
                rst_n   = ($urandom_range(0, 59) != 0);
                @(negedge clk);
            end
            start_a = 1'b0;
            start_b = 1'b0;
            rst_n   = 1'b1;
        end
        wait_idle();
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish t=%0t", $time);
        $fatal(1);
    end

endmodule
